ps2_key_display: RTL

- Upstream stage of the 7-segment decoders.
- Receives raw PS/2 keyboard frames, validates them, tracks make/break codes, and counts key presses in BCD.
- Presents 4-bit nibbles (scancode hi/lo, press count tens/ones) plus a blank flag, ready to drive one bcd7seg instance per digit.

---
 rtl/ps2_key_display.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_display.sv
// ps2_key_display: PS/2 keyboard front end for a row of 7-segment digits.
// Synchronises the raw PS/2 lines, assembles and validates 11-bit frames,
// follows make/break sequences and counts key presses in two BCD digits.
// Optional feature macro: PS2_ASCII_EN (set-2 scancode to ASCII table).
module ps2_key_display #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       key_down,
  output logic       blank,
  output logic       frame_err,
  output logic [7:0] ascii
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_BREAK, S_BREAK_IDLE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   fall_p0;
  logic                   dat_p0;
  logic [3:0]             bitcnt;
  logic [9:0]             frame_p0;
  logic [TW-1:0]          tcnt;
  logic                   vld_p1;
  logic [7:0]             byte_p1;
  logic                   frame_ok;
  state_t                 state, nstate;
  logic [7:0]             key_code;
  logic [7:0]             cnt;
  logic                   nkey_down, latch, inc;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t, o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // Synchronisers idle high, matching the PS/2 bus idle level.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  // ---- stage p0: falling-edge detect and bit sample
  assign fall_p0 = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat_p0  = dat_sync[SYNC_STAGES-1];

  // frame_p0 holds start, d0..d7, parity; the stop bit is checked live.
  assign frame_ok = ~frame_p0[0] & dat_p0 & (^frame_p0[9:1]);

  // Bit collection, frame validation and partial-frame timeout.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bitcnt    <= 4'd0;
      frame_p0  <= 10'd0;
      tcnt      <= '0;
      vld_p1    <= 1'b0;
      byte_p1   <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      frame_err <= 1'b0;
      if (fall_p0) begin
        tcnt <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt    <= 4'd0;
          vld_p1    <= frame_ok;
          frame_err <= ~frame_ok;
          byte_p1   <= frame_p0[8:1];
        end else begin
          frame_p0[bitcnt] <= dat_p0;
          bitcnt           <= bitcnt + 4'd1;
        end
      end else if (bitcnt == 4'd0) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
        tcnt   <= '0;
        bitcnt <= 4'd0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // ---- stage p1: delivered byte drives the make/break FSM
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= nstate;
  end

  // Next state plus key latch / count-increment strobes.
  always_comb begin
    nstate    = state;
    nkey_down = key_down;
    latch     = 1'b0;
    inc       = 1'b0;
    if (vld_p1) begin
      unique case (state)
        S_IDLE: begin
          if (byte_p1 == 8'hF0) begin
            nstate = S_BREAK_IDLE;
          end else if (byte_p1 != 8'hE0) begin
            latch     = 1'b1;
            inc       = 1'b1;
            nkey_down = 1'b1;
            nstate    = S_HELD;
          end
        end
        S_HELD: begin
          if (byte_p1 == 8'hF0) begin
            nstate = S_BREAK;
          end else if (byte_p1 != 8'hE0 && byte_p1 != key_code) begin
            latch = 1'b1;
            inc   = 1'b1;
          end
        end
        S_BREAK: begin
          if (byte_p1 == key_code) begin
            nkey_down = 1'b0;
            nstate    = S_IDLE;
          end else begin
            nstate = S_HELD;
          end
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  // Registered display state, updated with the FSM transition.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_code <= 8'd0;
      key_down <= 1'b0;
      cnt      <= 8'd0;
    end else begin
      key_down <= nkey_down;
      if (latch) key_code <= byte_p1;
      if (inc)   cnt      <= bcd_inc(cnt);
    end
  end

`ifdef PS2_ASCII_EN
  logic [7:0] ascii_r;

  // Set-2 scancode to lowercase ASCII; unmapped codes give 0.
  function automatic logic [7:0] to_ascii(input logic [7:0] sc);
    case (sc)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
      8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
      8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
      8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
      8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
      8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
      8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
      8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
      8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
      8'h46: return 8'h39; 8'h29: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // ASCII is latched together with key_code and held after release.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)      ascii_r <= 8'h00;
    else if (latch) ascii_r <= to_ascii(byte_p1);
  end

  assign ascii = ascii_r;
`else
  assign ascii = 8'h00;
`endif

  assign code_hi  = key_code[7:4];
  assign code_lo  = key_code[3:0];
  assign cnt_tens = cnt[7:4];
  assign cnt_ones = cnt[3:0];
  assign blank    = ~key_down;

endmodule
